// File: rtl/multi_nch_disp_if.sv
// Channel bus for the seven-segment display multiplexer: per-channel inputs,
// scan controls and the registered selected-channel outputs.
interface multi_nch_disp_if #(
  parameter int unsigned CH = 8,
  parameter int unsigned DW = 32,
  parameter int unsigned PW = 8,
  parameter int unsigned SW = 3
);
  logic             EN;
  logic [SW-1:0]    Test;
  logic             auto_scan;
  logic             freeze;
  logic [CH*DW-1:0] Data_in;
  logic [CH*PW-1:0] LES;
  logic [CH*PW-1:0] point_in;
  logic [DW-1:0]    Disp_num;
  logic [PW-1:0]    LE_out;
  logic [PW-1:0]    point_out;
  logic [SW-1:0]    ch_active;
  logic             scan_tick;

  modport master (
    output EN, Test, auto_scan, freeze, Data_in, LES, point_in,
    input  Disp_num, LE_out, point_out, ch_active, scan_tick
  );

  modport slave (
    input  EN, Test, auto_scan, freeze, Data_in, LES, point_in,
    output Disp_num, LE_out, point_out, ch_active, scan_tick
  );
endinterface

// File: rtl/multi_nch_disp.sv
// Display-data multiplexer: CPU-latched channel 0 plus CH-1 direct channels,
// manual or dwell-timed auto-scan selection, freeze, registered outputs.
module multi_nch_disp #(
  parameter int unsigned   CH       = 8,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   PW       = 8,
  parameter int unsigned   SW       = 3,
  parameter int unsigned   DWELL    = 50000000,
  parameter logic [DW-1:0] RST_DATA = DW'(32'hAA5555AA)
) (
  input logic              clk,
  input logic              rst,
  multi_nch_disp_if.slave  bus
);
  localparam int unsigned   CW       = $clog2(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(CH - 1);

  logic [DW-1:0] cpu_data;
  logic [PW-1:0] cpu_blink;
  logic [PW-1:0] cpu_point;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [SW-1:0] sel_c;
  logic          tick_c;
  logic [DW-1:0] word_c;
  logic [PW-1:0] blink_c;
  logic [PW-1:0] point_c;

  // Channel-0 CPU latch; loads even while frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_data  <= RST_DATA;
      cpu_blink <= '1;
      cpu_point <= '0;
    end else if (bus.EN) begin
      cpu_data  <= bus.Data_in[DW-1:0];
      cpu_blink <= bus.LES[PW-1:0];
      cpu_point <= bus.point_in[PW-1:0];
    end
  end

  // Next select and dwell count; auto mode rotates from the current channel
  always_comb begin
    cnt_d  = cnt_q;
    sel_c  = bus.ch_active;
    tick_c = 1'b0;
    if (!bus.freeze) begin
      if (!bus.auto_scan) begin
        cnt_d = '0;
        sel_c = (32'(bus.Test) < CH) ? bus.Test : '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_c = 1'b1;
        sel_c  = (bus.ch_active == CH_LAST) ? '0 : bus.ch_active + SW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Channel mux; channel 0 always comes from the latch, never bypassed
  always_comb begin
    word_c  = cpu_data;
    blink_c = cpu_blink;
    point_c = cpu_point;
    for (int k = 1; k < int'(CH); k++) begin
      if (sel_c == SW'(k)) begin
        word_c  = bus.Data_in[k*DW +: DW];
        blink_c = bus.LES[k*PW +: PW];
        point_c = bus.point_in[k*PW +: PW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      bus.ch_active <= '0;
      bus.Disp_num  <= RST_DATA;
      bus.LE_out    <= '1;
      bus.point_out <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!bus.freeze) begin
        bus.ch_active <= sel_c;
        bus.Disp_num  <= word_c;
        bus.LE_out    <= blink_c;
        bus.point_out <= point_c;
      end
    end
  end

  assign bus.scan_tick = tick_c;
endmodule
